gpio_bank_ctrl: RTL
===================

# gpio_bank_ctrl

Parametrised, memory-mapped GPIO controller that replaces the processor's fixed two-port, 36-bit GPIO and raw 4-bit switch wiring.
- Provides CHANNELS independent WIDTH-bit GPIO ports, each with:
  - per-bit direction control;
  - atomic set/clear of output bits;
  - a two-flop input synchronizer;
  - rising/falling edge capture into sticky status bits.
- Also debounces SW_W switch inputs and produces one registered interrupt line.
- Sits on the processor's data-memory bus as a peripheral slave.

## Interface
- CHANNELS, 2, number of GPIO ports (1–8)
- WIDTH, 36, bits per GPIO port; also the bus data width
- ADDR_W, 24, bus address width (word addresses)
- BASE, 0, word address of register 0
- SW_W, 4, number of switch inputs
- DEB_CYCLES, 16, stable cycles required before a debounced switch bit changes (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- addr  in  ADDR_W  word address
- we  in  1  write strobe, one cycle per write
- re  in  1  read strobe, one cycle per read
- wdata  in  WIDTH  write data
- rdata  out  WIDTH  registered read data
- gpio_in  in  CHANNELS*WIDTH  pad inputs; channel c occupies bits [c*WIDTH +: WIDTH]
- gpio_out  out  CHANNELS*WIDTH  output data register contents
- gpio_oe  out  CHANNELS*WIDTH  output enable (= DIR register)
- switches  in  SW_W  raw asynchronous switch inputs
- irq  out  1  registered OR of all STATUS bits

## Operation
- Register map: offset = addr − BASE. Channel c occupies offsets c*8 … c*8+7:
  - +0 IN: read-only, synchronized pad value.
  - +1 OUT: read/write.
  - +2 DIR: read/write; 1 = output.
  - +3 RISE_EN: read/write.
  - +4 FALL_EN: read/write.
  - +5 STATUS: read; writing 1 clears that bit (W1C).
  - +6 SET: write-only; OUT |= wdata; reads return 0.
  - +7 CLR: write-only; OUT &= ~wdata; reads return 0.
- Switch register: offset CHANNELS*8 is SW, read-only, debounced switches in bits [SW_W-1:0], upper bits 0.
- Unmapped offsets, and any addr < BASE: reads return 0, writes are ignored.
- we and re asserted together: write and read both act. The read returns the pre-write value.
- Input path: gpio_in → sync1 → sync2 (the IN value) → prev.
  - rise = sync2 & ~prev & RISE_EN.
  - fall = ~sync2 & prev & FALL_EN.
  - STATUS |= rise | fall.
- Same-cycle conflict: if an edge sets a STATUS bit in the same cycle as a W1C write to that bit, the set wins.
- Enables gate setting only. Clearing RISE_EN/FALL_EN does not clear STATUS.
- gpio_in is sampled on every bit regardless of DIR. Input bits are not forced to a value.
- Debouncer, per switch bit: raw → 2-flop sync → compare with the debounced value.
  - While they differ, a per-bit counter increments.
  - When the counter reaches DEB_CYCLES−1 and they still differ, the debounced bit takes the synced value and the counter resets.
  - Any cycle where they are equal resets the counter.
- irq_next = OR over all channels of STATUS; irq registers irq_next.

## Timing
- Reset (rst = 0 at a rising edge) clears everything:
  - OUT, DIR, RISE_EN, FALL_EN, STATUS, sync flops, prev, debounced switches, counters → 0.
  - rdata = 0, irq = 0, gpio_out = 0, gpio_oe = 0.
- Reset asserted mid-operation takes effect at that edge. Any in-flight read returns 0 in the next cycle.
- Write latency: the register updates at the edge where we = 1. gpio_out/gpio_oe reflect it immediately after that edge.
- Read latency: 1 cycle. rdata is valid after the edge following the re cycle. rdata holds its last value when re = 0.
- Input latency: if gpio_in changes before edge k:
  - IN is readable (sync2) after edge k+1;
  - STATUS is set after edge k+2;
  - irq rises after edge k+3.
- W1C clearing the last set STATUS bit: irq falls one cycle after STATUS clears.
- Pulse rule: input pulses shorter than one clock period may be missed. Pulses of 2 or more cycles are always captured.
- Debounce latency: a clean switch change before edge k appears in SW after edge k+1+DEB_CYCLES. A bounce resets the count.

## Test plan
- Reset: drive rst = 0 for 2 cycles with random bus and pad activity, then read every offset → all 0. gpio_out = 0, gpio_oe = 0, irq = 0.
- Set/clear sequence on channel 1 (default params, BASE = 0):
  - write OUT (addr 9) = 36'hF_0000_00FF;
  - SET (addr 14) with 36'h0_0000_FF00;
  - CLR (addr 15) with 36'hF_0000_0000.
  - Read addr 9 → 36'h0_0000_FFFF, and gpio_out[71:36] equals it.
- Edge capture on channel 0:
  - RISE_EN = 1; drive gpio_in[0] 0→1 → STATUS[0] = 1 three edges later and irq = 1 one edge after that.
  - Drive 1→0 with FALL_EN = 0 → no new status.
  - W1C 1 to addr 5 → STATUS = 0 and irq drops one cycle later.
- Set-wins conflict: align a rising edge on gpio_in[3] so STATUS is set in the same cycle as a W1C write of bit 3 → STATUS[3] reads 1.
- Debounce (DEB_CYCLES = 16):
  - toggle switches[2] for 5 cycles with bounce → SW unchanged;
  - hold it at 1 for 16 cycles → SW = 4'b0100 after edge k+17.
- Unmapped and simultaneous access: read addr 17 → 0 and write there has no effect; we + re on OUT in the same cycle → rdata shows the old value and the next read shows the new value.

Source files
------------

// File: rtl/gpio_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bank_ctrl
// Brief    : Memory-mapped multi-channel GPIO bank with edge-capture status,
//            switch debouncing and a single registered interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_bank_ctrl #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 36,
    parameter int ADDR_W     = 24,
    parameter int BASE       = 0,
    parameter int SW_W       = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      we,
    input  logic                      re,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    input  logic [CHANNELS*WIDTH-1:0] gpio_in,
    output logic [CHANNELS*WIDTH-1:0] gpio_out,
    output logic [CHANNELS*WIDTH-1:0] gpio_oe,
    input  logic [SW_W-1:0]           switches,
    output logic                      irq
);

    localparam int                c_cnt_w    = $clog2(DEB_CYCLES);
    localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] c_sw_off   = ADDR_W'(CHANNELS * 8);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic                             w_mapped;
    logic [ADDR_W-1:0]                w_off;
    logic                             w_ch_hit;
    logic                             w_sw_hit;
    logic [2:0]                       w_ch;
    logic [2:0]                       w_reg;
    logic [CHANNELS-1:0][WIDTH-1:0]   w_rd_ch;
    logic [CHANNELS-1:0]              w_status_any;
    logic [WIDTH-1:0]                 w_rd_val;

    logic [WIDTH-1:0]                 r_rdata;
    logic                             r_irq;
    logic [SW_W-1:0]                  r_sw_s1;
    logic [SW_W-1:0]                  r_sw_s2;
    logic [SW_W-1:0]                  r_sw_deb;
    logic [c_cnt_w-1:0]               r_sw_cnt [SW_W];

    assign w_mapped = (addr >= c_base);
    assign w_off    = addr - c_base;
    assign w_ch_hit = w_mapped && (w_off < c_sw_off);
    assign w_sw_hit = w_mapped && (w_off == c_sw_off);
    assign w_ch     = w_off[5:3];
    assign w_reg    = w_off[2:0];

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic             w_sel;
            logic [WIDTH-1:0] w_edges;
            logic [WIDTH-1:0] w_clr;
            logic [WIDTH-1:0] w_rd;
            logic [WIDTH-1:0] r_out;
            logic [WIDTH-1:0] r_dir;
            logic [WIDTH-1:0] r_rise_en;
            logic [WIDTH-1:0] r_fall_en;
            logic [WIDTH-1:0] r_status;
            logic [WIDTH-1:0] r_sync1;
            logic [WIDTH-1:0] r_sync2;
            logic [WIDTH-1:0] r_prev;

            assign w_sel   = w_ch_hit && (w_ch == 3'(c));
            assign w_edges = (r_sync2 & ~r_prev & r_rise_en) |
                             (~r_sync2 & r_prev & r_fall_en);
            assign w_clr   = (we && w_sel && (w_reg == 3'd5)) ? wdata : '0;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_out     <= '0;
                    r_dir     <= '0;
                    r_rise_en <= '0;
                    r_fall_en <= '0;
                    r_status  <= '0;
                    r_sync1   <= '0;
                    r_sync2   <= '0;
                    r_prev    <= '0;
                end else begin
                    r_sync1 <= gpio_in[c*WIDTH +: WIDTH];
                    r_sync2 <= r_sync1;
                    r_prev  <= r_sync2;
                    if (we && w_sel) begin
                        case (w_reg)
                            3'd1:    r_out     <= wdata;
                            3'd2:    r_dir     <= wdata;
                            3'd3:    r_rise_en <= wdata;
                            3'd4:    r_fall_en <= wdata;
                            3'd6:    r_out     <= r_out | wdata;
                            3'd7:    r_out     <= r_out & ~wdata;
                            default: ;
                        endcase
                    end
                    // A freshly detected edge overrides a same-cycle W1C.
                    r_status <= (r_status & ~w_clr) | w_edges;
                end
            end

            always_comb begin
                w_rd = '0;
                if (w_sel) begin
                    case (w_reg)
                        3'd0:    w_rd = r_sync2;
                        3'd1:    w_rd = r_out;
                        3'd2:    w_rd = r_dir;
                        3'd3:    w_rd = r_rise_en;
                        3'd4:    w_rd = r_fall_en;
                        3'd5:    w_rd = r_status;
                        default: w_rd = '0;
                    endcase
                end
            end

            assign w_rd_ch[c]                 = w_rd;
            assign w_status_any[c]            = |r_status;
            assign gpio_out[c*WIDTH +: WIDTH] = r_out;
            assign gpio_oe[c*WIDTH +: WIDTH]  = r_dir;
        end
    endgenerate

    // Channel read values are pre-gated by their own select, so OR-merge.
    always_comb begin
        w_rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_rd_val = w_rd_val | w_rd_ch[c];
        end
        if (w_sw_hit) begin
            w_rd_val = WIDTH'(r_sw_deb);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (re) begin
                r_rdata <= w_rd_val;
            end
            r_irq <= |w_status_any;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_sw_deb <= '0;
            for (int i = 0; i < SW_W; i++) begin
                r_sw_cnt[i] <= '0;
            end
        end else begin
            r_sw_s1 <= switches;
            r_sw_s2 <= r_sw_s1;
            for (int i = 0; i < SW_W; i++) begin
                if (r_sw_s2[i] != r_sw_deb[i]) begin
                    if (r_sw_cnt[i] == c_cnt_last) begin
                        r_sw_deb[i] <= r_sw_s2[i];
                        r_sw_cnt[i] <= '0;
                    end else begin
                        r_sw_cnt[i] <= r_sw_cnt[i] + 1'b1;
                    end
                end else begin
                    r_sw_cnt[i] <= '0;
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;

endmodule
`default_nettype wire
